// File: rtl/vga_scanout_if.sv
// vga_scanout_if: VRAM read port plus VGA connector pins between scan-out engine and board
// master: drives vgac_addr, colour, syncs and vblank; samples vgac_data
// slave: returns vgac_data one clk after vgac_addr; observes the pins
interface vga_scanout_if;
  logic [15:0] vgac_addr;
  logic [15:0] vgac_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vblank;
  modport master (output vgac_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vblank, input vgac_data);
  modport slave (input vgac_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vblank, output vgac_data);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 scan-out of a 240x160 BGR555 frame, 2x scaled in a bordered window
// clk/rst: system clock, async active-high reset
// vga: VRAM read address/data, 4-bit colour pins, active-low syncs, vblank
module vga_scanout #(
  parameter int CLK_DIV = 2,
  parameter int WIN_X   = 80,
  parameter int WIN_Y   = 80
) (
  input logic            clk,
  input logic            rst,
  vga_scanout_if.master  vga
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] X0 = 10'(WIN_X);
  localparam logic [9:0] X1 = 10'(WIN_X + 480);
  localparam logic [9:0] Y0 = 10'(WIN_Y);
  localparam logic [9:0] Y1 = 10'(WIN_Y + 320);
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic [7:0]    col_q, col_d;
  logic [15:0]   row_q, row_d, addr_q, addr_d;
  logic          win1_q, hs1_q, vs1_q, vb1_q;
  logic [3:0]    r_q, g_q, b_q;
  logic          hs2_q, vs2_q, vb2_q;
  logic          pix_en, h_end, v_end, hwin, vwin, win, hodd, vodd, hs_n, vs_n;
  always_comb begin
    pix_en = div_q == DIV_MAX;
    h_end  = h_q == 10'd799;
    v_end  = v_q == 10'd524;
    hwin   = h_q >= X0 && h_q < X1;
    vwin   = v_q >= Y0 && v_q < Y1;
    win    = hwin && vwin;
    // odd offset from the window origin, i.e. the second of each doubled pixel/line
    hodd   = h_q[0] ^ X0[0];
    vodd   = v_q[0] ^ Y0[0];
    hs_n   = !(h_q >= 10'd656 && h_q < 10'd752);
    vs_n   = !(v_q >= 10'd490 && v_q < 10'd492);
    div_d  = pix_en ? '0 : div_q + 1'b1;
    h_d    = h_end ? '0 : h_q + 10'd1;
    v_d    = h_end ? (v_end ? '0 : v_q + 10'd1) : v_q;
    col_d  = h_end ? '0 : (hwin && hodd) ? col_q + 8'd1 : col_q;
    row_d  = !h_end ? row_q : v_end ? '0 : (vwin && vodd) ? row_q + 16'd240 : row_q;
    addr_d = win ? row_q + {8'd0, col_q} : addr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
      win1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      vb1_q  <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      vb2_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      if (pix_en) begin
        h_q    <= h_d;
        v_q    <= v_d;
        col_q  <= col_d;
        row_q  <= row_d;
        addr_q <= addr_d;
        win1_q <= win;
        hs1_q  <= hs_n;
        vs1_q  <= vs_n;
        vb1_q  <= v_q >= 10'd480;
        r_q    <= win1_q ? vga.vgac_data[4:1] : '0;
        g_q    <= win1_q ? vga.vgac_data[9:6] : '0;
        b_q    <= win1_q ? vga.vgac_data[14:11] : '0;
        hs2_q  <= hs1_q;
        vs2_q  <= vs1_q;
        vb2_q  <= vb1_q;
      end
    end
  end
  assign vga.vgac_addr = addr_q;
  assign vga.vga_r     = r_q;
  assign vga.vga_g     = g_q;
  assign vga.vga_b     = b_q;
  assign vga.vga_hs    = hs2_q;
  assign vga.vga_vs    = vs2_q;
  assign vga.vblank    = vb2_q;
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Scan-out engine that drives the VGA connector from the bitmap frame buffer held in the memory block's dual-port VRAM. It generates 640x480@60 Hz timing, computes the halfword read address sent on the VRAM read port (`vgac_addr`), and registers the returned 16-bit BGR555 pixel (`vgac_data`) onto 4-bit-per-channel colour pins. The 240x160 frame is shown 2x-scaled in a centred 480x320 window with a black border. `vblank` is exported for the CPU interrupt logic.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; legal values are >= 2.
- `WIN_X`, 80: first visible column of the scaled window.
- `WIN_Y`, 80: first visible line of the scaled window.
- `clk`  in  1: system clock; every register is clocked on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `vgac_addr`  out  16: VRAM halfword read address; the VRAM returns `vgac_data` one `clk` after sampling it.
- `vgac_data`  in  16: pixel; R=[4:0], G=[9:5], B=[14:10], bit 15 ignored.
- `vga_r`, `vga_g`, `vga_b`  out  4 each: colour outputs.
- `vga_hs`, `vga_vs`  out  1 each: sync outputs, active low.
- `vblank`  out  1: high while the line counter `v` is >= 480.

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps. `pix_en` is high when `div`==CLK_DIV-1. All state below advances only on `pix_en`.
- Horizontal counter `h` runs 0..799, then wraps to 0. On that wrap, vertical counter `v` increments 0..524, then wraps to 0.
- Horizontal phases: active 0-639; front porch 640-655; sync 656-751 (`hs_n`=0); back porch 752-799.
- Vertical phases: active 0-479; front porch 480-489; sync 490-491 (`vs_n`=0); back porch 492-524.
- Window condition `win` = (WIN_X <= h < WIN_X+480) && (WIN_Y <= v < WIN_Y+320).
- Source coordinates: `px`=(h-WIN_X)>>1 in 0..239; `py`=(v-WIN_Y)>>1 in 0..159.
- Address: `addr`=py*240+px, range 0..38399, 16-bit, no wrap needed.
  - Generated incrementally, with no multiplier. `row_base` is cleared at `v`==0 and gains 240 after every odd window line. Column offset `px` increments on every second window pixel.
- Pipeline stage 1, on `pix_en` with counters at (h,v): `vgac_addr`<=`addr` if `win` (otherwise it holds its value); `win_d`<=`win`; `hs_d`<=`hs_n`; `vs_d`<=`vs_n`.
- Pipeline stage 2, on the next `pix_en`:
  - `{vga_r,vga_g,vga_b}` <= `win_d` ? {data[4:1], data[9:6], data[14:11]} : 0.
  - `vga_hs`<=`hs_d`; `vga_vs`<=`vs_d`.
- `vblank` is registered with stage 2 from `v`>=480, so it is aligned with the sync outputs.
- Pixels outside the window, including all porches and sync periods, drive colour 0.

## Timing
- Reset values: `div`=0, `h`=0, `v`=0, `row_base`=0, `vgac_addr`=0, colour=0, `vga_hs`=1, `vga_vs`=1, `vblank`=0, and all pipeline registers inactive (`win_d`=0, `hs_d`=`vs_d`=1).
- Reset asserted mid-frame returns every output to its reset value immediately; no partial-line artefacts are required afterwards.
- After reset deassertion, the first `pix_en` occurs CLK_DIV clocks later, on the CLK_DIV-th rising edge after deassertion.
- Latency: counter value to pins is exactly 2 `pix_en` ticks, identical for colour, syncs and `vblank`.
- VRAM data is sampled at least CLK_DIV-1 >= 1 clocks after `vgac_addr` changes, which satisfies the 1-clock read latency.
- `vgac_addr` changes at most once per `pix_en`, and only when `win` is true.
- Frame period is 800*525 `pix_en` ticks. `hs` is low for 96 ticks per line; `vs` is low for 1600 ticks per frame.
- Simultaneous `h` wrap and `v` wrap (h=799, v=524) both wrap to 0 on the same tick; `row_base` clears on that same tick.

## Test plan
- Reset check: hold `rst`=1 for 5 clocks, then release. Required: outputs at reset values; first `pix_en` on the 2nd clock edge after release (CLK_DIV=2); `vga_hs` first falls 656+2 pixel ticks later.
- Line timing: run 3 lines. Required: `vga_hs` period 800 ticks, low width 96 ticks; colour is 0 outside h 80..559 (+2 ticks latency).
- Frame timing: run 1 full frame. Required: `vga_vs` low for exactly 1600 ticks starting at line 490; `vblank` high for lines 480..524 (45 lines); frame length 420000 ticks.
- Address sequence: probe `vgac_addr`.
  - (h=80,v=80)->0; (82,80)->1; (81,81)->0; (80,82)->240.
  - (559,399)->38399.
  - Address then holds outside the window.
- Colour mapping: model the VRAM as data = f(addr).
  - 16'h7FFF -> F,F,F; 16'h001F -> R=F, G=0, B=0; 16'h03E0 -> G only; 16'h7C00 -> B only; 16'h8000 -> 0,0,0.
  - Each value appears 2 ticks after its address and lasts 2 ticks (horizontal 2x).
- Reset mid-frame: assert `rst` at line 200, pixel 300 for 1 clock. Required: colour=0 and `vga_hs`=`vga_vs`=1 in the same cycle; the next frame's addresses start at 0 at (80,80).
